// File: rtl/alu_multiply_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_multiply_sequencer_if
// Operand/function-select bus between the multiply sequencer (initiator)
// and the shared 32-bit ALU.
//   AluA, AluB  : 32-bit ALU operands           (initiator -> ALU)
//   AluFunSel   : 5-bit ALU function select     (initiator -> ALU)
//   AluWF       : ALU flag write enable         (initiator -> ALU)
//   AluOut      : 32-bit combinational result   (ALU -> initiator)
//   AluFlags    : registered flags {Z,C,N,O}    (ALU -> initiator)
// Handshake: there is no valid/ready pair on this bus. The ALU is purely
// combinational to AluOut, so a request driven in a cycle is answered in
// that same cycle; AluWF=1 commits the flags at the next rising edge.
// ---------------------------------------------------------------------------
interface alu_multiply_sequencer_if;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [31:0] AluOut;
  logic [3:0]  AluFlags;

  modport master (
    output AluA, AluB, AluFunSel, AluWF,
    input  AluOut, AluFlags
  );

  modport slave (
    input  AluA, AluB, AluFunSel, AluWF,
    output AluOut, AluFlags
  );
endinterface

// File: rtl/alu_multiply_sequencer.sv
// ---------------------------------------------------------------------------
// alu_multiply_sequencer
// 16x16 unsigned shift-and-add multiplier that performs no arithmetic of its
// own: each multiplier bit costs one ALU cycle (32-bit ADD or pass-A) and
// one internal shift cycle. Fixed latency of 33 cycles per operation.
// Ports:
//   Clock, Reset   : clock, synchronous active-high reset
//   Start          : request, only honoured in IDLE
//   Multiplicand   : operand X (16 bit), captured with Start
//   Multiplier     : operand Y (16 bit), captured with Start
//   Busy           : high from the cycle after Start through DONE
//   Done           : one-cycle pulse in DONE
//   Product        : registered X*Y, held until the next accepted Start
//   ProductZero    : registered Z flag of the final ADD
//   DbgState       : current FSM state (debug observation)
//   alu            : ALU operand/function-select bus (initiator side)
// ---------------------------------------------------------------------------
module alu_multiply_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Multiplicand,
  input  logic [15:0] Multiplier,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product,
  output logic        ProductZero,
  output logic [1:0]  DbgState,
  alu_multiply_sequencer_if.master alu
);

  localparam logic [4:0] FUN_PASS_A = 5'b10000;
  localparam logic [4:0] FUN_ADD    = 5'b10100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [15:0] r_mplier;
  logic [3:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_product;
  logic        r_product_zero;

  // Only Z is meaningful: the product never exceeds 32 bits, so C/N/O
  // carry no information for this block.
  logic w_flags_unused;
  assign w_flags_unused = ^alu.AluFlags[2:0];

  // Next-state and bus decode; the bus depends only on state and registers.
  always_comb begin
    w_next        = r_state;
    alu.AluA      = 32'd0;
    alu.AluB      = 32'd0;
    alu.AluFunSel = FUN_PASS_A;
    alu.AluWF     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_ADD;
      end
      S_ADD: begin
        alu.AluA      = r_acc;
        alu.AluB      = r_mcand;
        alu.AluWF     = 1'b1;
        // Multiplier bit 0 chooses between accumulating and passing acc.
        alu.AluFunSel = r_mplier[0] ? FUN_ADD : FUN_PASS_A;
        w_next        = S_SHIFT;
      end
      S_SHIFT: begin
        // count is checked before its increment: 15 means 16th bit done.
        w_next = (r_count == 4'd15) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_acc          <= 32'd0;
      r_mcand        <= 32'd0;
      r_mplier       <= 16'd0;
      r_count        <= 4'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_product      <= 32'd0;
      r_product_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      // Busy/Done are registered copies of where the FSM is heading, so
      // they line up exactly with the state they describe.
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_acc          <= 32'd0;
            r_mcand        <= {16'd0, Multiplicand};
            r_mplier       <= Multiplier;
            r_count        <= 4'd0;
            r_product      <= 32'd0;
            r_product_zero <= 1'b0;
          end
        end
        S_ADD: begin
          r_acc <= alu.AluOut;
        end
        S_SHIFT: begin
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 4'd1;
        end
        S_DONE: begin
          r_product      <= r_acc;
          // Flags still hold the Z written by the final ADD (SHIFT has WF=0).
          r_product_zero <= alu.AluFlags[3];
        end
        default: ;
      endcase
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Product     = r_product;
  assign ProductZero = r_product_zero;
  assign DbgState    = r_state;

endmodule
